// File: rtl/bgpu_dispatch_pkg.sv
// Shared definitions for the dispatch control window.
// Holds register offsets, status bit positions, the FSM state type,
// the thread-block request bundle and a byte-enable merge helper.
package bgpu_dispatch_pkg;

   // Default widths. The tblock bundle is built from these, so the top-level
   // width parameters must keep these values.
   localparam int unsigned DispPcWidth     = 32;
   localparam int unsigned DispCntWidth    = 8;
   localparam int unsigned DispTgroupWidth = 8;

   // Byte offsets from the window base.
   localparam int unsigned DispPcOff     = 'h00;
   localparam int unsigned DispDpOff     = 'h04;
   localparam int unsigned DispNumOff    = 'h08;
   localparam int unsigned DispTgroupOff = 'h0C;
   localparam int unsigned DispCtrlOff   = 'h10;

   // CTRL/STATUS read layout.
   localparam int unsigned StatPendingBit  = 0;
   localparam int unsigned StatRunningBit  = 1;
   localparam int unsigned StatFinishedBit = 2;
   localparam int unsigned StatFinCntLsb   = 4;
   localparam int unsigned StatDispCntLsb  = 24;

   typedef enum logic [2:0] {
      DispIdle,
      DispLaunch,
      DispDispatch,
      DispWaitDone,
      DispDone
   } dispatch_state_e;

   typedef struct packed {
      logic [DispPcWidth-1:0]     pc;
      logic [DispPcWidth-1:0]     dp_addr;
      logic [DispCntWidth-1:0]    id;
      logic [DispTgroupWidth-1:0] tgroup;
   } tblock_req_t;

   // Replace the bytes of old selected by be with the bytes of wdata.
   function automatic logic [31:0] be_merge(input logic [31:0] old,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/bgpu_dispatch_fsm.sv
// Launch sequencer: walks IDLE -> LAUNCH -> DISPATCH -> WAIT_DONE -> DONE,
// offers one thread block per handshake and counts dispatches/completions.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             accepted CTRL write (only raised from IDLE/DONE)
//   num_tblocks       number of blocks to launch
//   tblock_ready      dispatcher accepts the offered block
//   tblock_done       one-cycle completion pulse
//   tblock_valid      block offered
//   start_pending, running, finished   status flags
//   dispatched_cnt, finished_cnt       progress counters
module bgpu_dispatch_fsm
   import bgpu_dispatch_pkg::*;
#(
   parameter int unsigned CntWidth = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [CntWidth-1:0] num_tblocks,
   input  logic                tblock_ready,
   input  logic                tblock_done,
   output logic                tblock_valid,
   output logic                start_pending,
   output logic                running,
   output logic                finished,
   output logic [CntWidth-1:0] dispatched_cnt,
   output logic [CntWidth-1:0] finished_cnt
);

   dispatch_state_e state_q, state_d;
   logic hs, done_ok, idle_like, counting;

   assign idle_like = (state_q == DispIdle) || (state_q == DispDone);
   assign counting  = (state_q == DispDispatch) || (state_q == DispWaitDone);
   assign hs        = (state_q == DispDispatch) && tblock_ready;
   // Compare against the post-handshake dispatch count so a completion in the
   // same cycle as a handshake is kept; anything beyond that is dropped.
   assign done_ok   = tblock_done && counting &&
                      ({1'b0, finished_cnt} < ({1'b0, dispatched_cnt} + (CntWidth+1)'(hs)));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= DispIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      tblock_valid = 1'b0;
      running      = 1'b0;
      finished     = 1'b0;
      unique case (state_q)
         DispIdle: begin
            if (start) state_d = DispLaunch;
         end
         DispLaunch: begin
            running = 1'b1;
            state_d = (num_tblocks == '0) ? DispDone : DispDispatch;
         end
         DispDispatch: begin
            running      = 1'b1;
            tblock_valid = 1'b1;
            if (hs && (dispatched_cnt + CntWidth'(1) == num_tblocks)) state_d = DispWaitDone;
         end
         DispWaitDone: begin
            running = 1'b1;
            if (finished_cnt == num_tblocks) state_d = DispDone;
         end
         DispDone: begin
            finished = 1'b1;
            if (start) state_d = DispLaunch;
         end
         default: state_d = DispIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_pending  <= 1'b0;
         dispatched_cnt <= '0;
         finished_cnt   <= '0;
      end else if (start && idle_like) begin
         start_pending  <= 1'b1;
         dispatched_cnt <= '0;
         finished_cnt   <= '0;
      end else begin
         if (state_q == DispLaunch) start_pending <= 1'b0;
         if (hs)      dispatched_cnt <= dispatched_cnt + CntWidth'(1);
         if (done_ok) finished_cnt   <= finished_cnt + CntWidth'(1);
      end
   end

endmodule

// File: rtl/bgpu_dispatch_ctrl_regs.sv
// Dispatch control register window on the SoC register bus.
// Decodes the 5-word window, holds the kernel launch configuration and
// hands the launch over to bgpu_dispatch_fsm.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_*                  register request (always accepted)
//   rsp_*                  registered response, one cycle after the request
//   tblock_*               thread-block offer / handshake / done pulse
//   busy_o                 launch in progress
module bgpu_dispatch_ctrl_regs
   import bgpu_dispatch_pkg::*;
#(
   parameter int unsigned          AddrWidth      = 32,
   parameter logic [AddrWidth-1:0] BaseAddr       = 32'hFFFFFF00,
   parameter int unsigned          PcWidth        = DispPcWidth,
   parameter int unsigned          TblockCntWidth = DispCntWidth,
   parameter int unsigned          TgroupIdWidth  = DispTgroupWidth
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [AddrWidth-1:0]      req_addr_i,
   input  logic                      req_we_i,
   input  logic [31:0]               req_wdata_i,
   input  logic [3:0]                req_be_i,
   output logic                      rsp_valid_o,
   output logic [31:0]               rsp_rdata_o,
   output logic                      rsp_error_o,
   output logic                      tblock_valid_o,
   input  logic                      tblock_ready_i,
   output logic [PcWidth-1:0]        tblock_pc_o,
   output logic [PcWidth-1:0]        tblock_dp_addr_o,
   output logic [TblockCntWidth-1:0] tblock_id_o,
   output logic [TgroupIdWidth-1:0]  tblock_tgroup_o,
   input  logic                      tblock_done_i,
   output logic                      busy_o
);

   logic [PcWidth-1:0]        pc_q, dp_q;
   logic [TblockCntWidth-1:0] num_q, disp_cnt, fin_cnt;
   logic [TgroupIdWidth-1:0]  tg_q;
   logic                      pending, running, finished;

   logic [AddrWidth-1:0] off;
   logic                 in_win, aligned, is_ctrl, is_cfg, err, start, cfg_we;
   logic [31:0]          rdata;
   tblock_req_t          tb_req;

   assign req_ready_o = 1'b1;

   // Addresses below the base wrap to a large offset, so one compare
   // covers both ends of the window.
   assign off     = req_addr_i - BaseAddr;
   assign in_win  = off <= AddrWidth'(DispCtrlOff);
   assign aligned = off[1:0] == 2'b00;
   assign is_ctrl = off == AddrWidth'(DispCtrlOff);
   assign is_cfg  = in_win && !is_ctrl;

   assign err = !in_win || !aligned ||
                (req_we_i && is_cfg && running) ||
                (req_we_i && is_ctrl && (running || pending));

   assign start  = req_valid_i && req_we_i && is_ctrl && !err;
   assign cfg_we = req_valid_i && req_we_i && is_cfg && !err;

   always_comb begin
      rdata = '0;
      unique case (off[4:0])
         5'(DispPcOff):     rdata = 32'(pc_q);
         5'(DispDpOff):     rdata = 32'(dp_q);
         5'(DispNumOff):    rdata = 32'(num_q);
         5'(DispTgroupOff): rdata = 32'(tg_q);
         5'(DispCtrlOff): begin
            rdata[StatPendingBit]                        = pending;
            rdata[StatRunningBit]                        = running;
            rdata[StatFinishedBit]                       = finished;
            rdata[StatFinCntLsb  +: TblockCntWidth]      = fin_cnt;
            rdata[StatDispCntLsb +: TblockCntWidth]      = disp_cnt;
         end
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pc_q        <= '0;
         dp_q        <= '0;
         num_q       <= '0;
         tg_q        <= '0;
         rsp_valid_o <= 1'b0;
         rsp_error_o <= 1'b0;
         rsp_rdata_o <= '0;
      end else begin
         rsp_valid_o <= req_valid_i;
         rsp_error_o <= req_valid_i && err;
         rsp_rdata_o <= (req_valid_i && !req_we_i && !err) ? rdata : '0;
         if (cfg_we) begin
            unique case (off[4:0])
               5'(DispPcOff):     pc_q  <= PcWidth'(be_merge(32'(pc_q), req_wdata_i, req_be_i));
               5'(DispDpOff):     dp_q  <= PcWidth'(be_merge(32'(dp_q), req_wdata_i, req_be_i));
               5'(DispNumOff):    num_q <= TblockCntWidth'(be_merge(32'(num_q), req_wdata_i, req_be_i));
               5'(DispTgroupOff): tg_q  <= TgroupIdWidth'(be_merge(32'(tg_q), req_wdata_i, req_be_i));
               default: ;
            endcase
         end
      end
   end

   bgpu_dispatch_fsm #(
      .CntWidth(TblockCntWidth)
   ) u_fsm (
      .clk           (clk_i),
      .rst_n         (rst_ni),
      .start         (start),
      .num_tblocks   (num_q),
      .tblock_ready  (tblock_ready_i),
      .tblock_done   (tblock_done_i),
      .tblock_valid  (tblock_valid_o),
      .start_pending (pending),
      .running       (running),
      .finished      (finished),
      .dispatched_cnt(disp_cnt),
      .finished_cnt  (fin_cnt)
   );

   assign tb_req = '{pc: pc_q, dp_addr: dp_q, id: disp_cnt, tgroup: tg_q};

   assign tblock_pc_o      = tb_req.pc;
   assign tblock_dp_addr_o = tb_req.dp_addr;
   assign tblock_id_o      = tb_req.id;
   assign tblock_tgroup_o  = tb_req.tgroup;
   assign busy_o           = running;

endmodule

// File: tb/tb_bgpu_dispatch_ctrl_regs.sv
module tb_bgpu_dispatch_ctrl_regs;

   localparam logic [31:0] BASE = 32'hFFFFFF00;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_addr_i = '0;
   logic        req_we_i = 1'b0;
   logic [31:0] req_wdata_i = '0;
   logic [3:0]  req_be_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_error_o;
   logic        tblock_valid_o;
   logic        tblock_ready_i = 1'b0;
   logic [31:0] tblock_pc_o, tblock_dp_addr_o;
   logic [7:0]  tblock_id_o, tblock_tgroup_o;
   logic        tblock_done_i = 1'b0;
   logic        busy_o;

   always #5 clk = ~clk;

   bgpu_dispatch_ctrl_regs dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
      .tblock_valid_o(tblock_valid_o), .tblock_ready_i(tblock_ready_i),
      .tblock_pc_o(tblock_pc_o), .tblock_dp_addr_o(tblock_dp_addr_o),
      .tblock_id_o(tblock_id_o), .tblock_tgroup_o(tblock_tgroup_o),
      .tblock_done_i(tblock_done_i), .busy_o(busy_o)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Launch progress is tracked as flags plus integer counts:
   // m_launch = first cycle after a start, m_run = launch in progress,
   // m_done = last launch finished.
   bit          m_on = 0;
   logic [31:0] m_pc, m_dp;
   int          m_num, m_tg, m_disp, m_fin;
   bit          m_launch, m_run, m_done;
   bit          e_rv, e_err;
   logic [31:0] e_rd;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
      return r;
   endfunction

   function automatic bit m_offer();
      return m_run && !m_launch && (m_disp < m_num);
   endfunction

   always @(posedge clk) begin
      bit hs, dn, bad, fin_now;
      logic [31:0] offl, rd;
      if (!rst_ni) begin
         m_on = 1; m_pc = 0; m_dp = 0; m_num = 0; m_tg = 0; m_disp = 0; m_fin = 0;
         m_launch = 0; m_run = 0; m_done = 0; e_rv = 0; e_err = 0; e_rd = 0;
      end else begin
         hs   = m_offer() && tblock_ready_i;
         dn   = tblock_done_i && m_run && !m_launch && (m_fin < m_disp + int'(hs));
         offl = req_addr_i - BASE;
         bad  = (offl > 16) || (req_addr_i[1:0] != 2'b00) ||
                (req_we_i && offl < 16 && m_run) ||
                (req_we_i && offl == 16 && (m_run || m_launch));
         case (offl)
            0:  rd = m_pc;
            4:  rd = m_dp;
            8:  rd = m_num;
            12: rd = m_tg;
            16: rd = int'(m_launch) + 2*int'(m_run) + 4*int'(m_done) + 16*m_fin + (m_disp << 24);
            default: rd = 0;
         endcase
         e_rv  = req_valid_i;
         e_err = req_valid_i && bad;
         e_rd  = (req_valid_i && !req_we_i && !bad) ? rd : 32'h0;
         fin_now = m_run && !m_launch && (m_disp == m_num) && (m_fin == m_num);
         if (m_launch) begin
            m_launch = 0;
            if (m_num == 0) begin m_run = 0; m_done = 1; end
         end else if (fin_now) begin
            m_run = 0; m_done = 1;
         end
         m_disp += int'(hs);
         m_fin  += int'(dn);
         if (req_valid_i && req_we_i && !bad) begin
            case (offl)
               0:  m_pc  = merge(m_pc, req_wdata_i, req_be_i);
               4:  m_dp  = merge(m_dp, req_wdata_i, req_be_i);
               8:  m_num = int'(merge(m_num, req_wdata_i, req_be_i) & 32'hFF);
               12: m_tg  = int'(merge(m_tg, req_wdata_i, req_be_i) & 32'hFF);
               default: begin
                  m_launch = 1; m_run = 1; m_done = 0; m_disp = 0; m_fin = 0;
               end
            endcase
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_on) begin
         check("busy", busy_o, m_run);
         check("tb_valid", tblock_valid_o, m_offer());
         if (m_offer()) begin
            check("tb_pc", tblock_pc_o, m_pc);
            check("tb_dp", tblock_dp_addr_o, m_dp);
            check("tb_id", tblock_id_o, m_disp);
            check("tb_tgroup", tblock_tgroup_o, m_tg);
         end
         check("rsp_valid", rsp_valid_o, e_rv);
         if (e_rv) begin
            check("rsp_rdata", rsp_rdata_o, e_rd);
            check("rsp_error", rsp_error_o, e_err);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   // Called at a negedge; returns at the negedge where the response is visible.
   task automatic bus(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd, output bit err);
      req_valid_i = 1; req_addr_i = addr; req_we_i = we; req_wdata_i = wd; req_be_i = be;
      @(negedge clk);
      req_valid_i = 0; req_we_i = 0;
      check("lit_rsp_valid", rsp_valid_o, 1);
      rd = rsp_rdata_o; err = rsp_error_o;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] wd, input bit exp_err);
      logic [31:0] rd; bit err;
      bus(BASE + off, 1, wd, 4'hF, rd, err);
      check("lit_wr_err", err, exp_err);
   endtask

   task automatic rdchk(input string name, input logic [31:0] off, input logic [31:0] exp);
      logic [31:0] rd; bit err;
      bus(BASE + off, 0, 0, 4'h0, rd, err);
      check(name, rd, exp);
      check("lit_rd_err", err, 0);
   endtask

   task automatic pulse_done(input int n);
      for (int k = 0; k < n; k++) begin
         tblock_done_i = 1; @(negedge clk);
         tblock_done_i = 0; @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] rd; bit err;
      logic [7:0] ids[$]; int cyc[$];

      repeat (2) @(negedge clk);
      rst_ni = 1;
      @(negedge clk);

      // reset values
      for (int o = 0; o <= 16; o += 4) rdchk("lit_reset_rd", o, 0);

      // configuration and readback
      wr(0, 32'h0, 0);
      wr(4, 32'h190, 0);
      wr(8, 32'hFFFFFF01, 0);
      wr(12, 32'h2, 0);
      rdchk("lit_pc", 0, 32'h0);
      rdchk("lit_dp", 4, 32'h190);
      rdchk("lit_num", 8, 32'h1);
      rdchk("lit_tg", 12, 32'h2);
      bus(BASE + 0, 1, 32'h12345678, 4'b0101, rd, err);
      rdchk("lit_pc_be", 0, 32'h00340078);
      wr(0, 32'h0, 0);
      bus(32'hFFFFFF20, 1, 32'h1, 4'hF, rd, err);
      check("lit_out_of_window", err, 1);
      bus(32'hFFFFFF06, 0, 0, 4'h0, rd, err);
      check("lit_unaligned", err, 1);
      bus(32'hFFFFFEFC, 0, 0, 4'h0, rd, err);
      check("lit_below_base", err, 1);

      // single block launch, held by the dispatcher
      wr(16, 32'h1, 0);
      check("lit_launch_busy", busy_o, 1);
      check("lit_launch_valid", tblock_valid_o, 0);
      @(negedge clk);
      check("lit_offer_valid", tblock_valid_o, 1);
      check("lit_offer_pc", tblock_pc_o, 0);
      check("lit_offer_dp", tblock_dp_addr_o, 32'h190);
      check("lit_offer_id", tblock_id_o, 0);
      check("lit_offer_tg", tblock_tgroup_o, 2);
      repeat (5) @(negedge clk);
      check("lit_held_dp", tblock_dp_addr_o, 32'h190);
      tblock_ready_i = 1; @(negedge clk); tblock_ready_i = 0;
      check("lit_valid_dropped", tblock_valid_o, 0);
      rdchk("lit_status_wait", 16, 32'h01000002);
      wr(16, 32'h1, 1);
      pulse_done(1);
      @(negedge clk);
      rdchk("lit_status_done", 16, 32'h01000014);
      check("lit_busy_done", busy_o, 0);

      // config write rejected mid-run
      wr(8, 32'h3, 0);
      wr(16, 32'h1, 0);
      @(negedge clk);
      wr(0, 32'hDEAD0000, 1);
      rdchk("lit_pc_unchanged", 0, 32'h0);
      tblock_ready_i = 1; repeat (3) @(negedge clk); tblock_ready_i = 0;
      pulse_done(3);
      @(negedge clk);
      rdchk("lit_status_num3", 16, 32'h03000034);

      // back-to-back dispatch with a completion on the second handshake
      wr(8, 32'h4, 0);
      wr(16, 32'h1, 0);
      tblock_ready_i = 1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         tblock_done_i = (c == 2);
         if (tblock_valid_o) begin ids.push_back(tblock_id_o); cyc.push_back(c); end
      end
      tblock_ready_i = 0; tblock_done_i = 0;
      check("lit_id_count", ids.size(), 4);
      for (int i = 0; i < ids.size() && i < 4; i++) begin
         check("lit_id_seq", ids[i], i);
         check("lit_id_cycle", cyc[i], i + 1);
      end
      pulse_done(3);
      @(negedge clk);
      rdchk("lit_status_num4", 16, 32'h04000044);

      // empty launch
      wr(8, 32'h0, 0);
      wr(16, 32'h1, 0);
      @(negedge clk);
      check("lit_empty_busy", busy_o, 0);
      rdchk("lit_status_empty", 16, 32'h00000004);

      // reset during dispatch
      wr(8, 32'h2, 0);
      wr(16, 32'h1, 0);
      @(negedge clk);
      check("lit_pre_reset_valid", tblock_valid_o, 1);
      rst_ni = 0;
      @(negedge clk);
      check("lit_reset_valid", tblock_valid_o, 0);
      check("lit_reset_busy", busy_o, 0);
      rst_ni = 1;
      @(negedge clk);
      for (int o = 0; o <= 16; o += 4) rdchk("lit_post_reset_rd", o, 0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bgpu_dispatch_ctrl_regs.md
Name: bgpu_dispatch_ctrl_regs

Overview:
- Memory-mapped responder for the dispatch control window at 0xFFFFFF00–0xFFFFFF10, reached over the SoC register bus (the JTAG system-bus master writes here).
- Holds kernel launch parameters: PC, data-pointer address, number of thread blocks, thread-group ID.
- On a start write, hands one thread block per handshake to the compute-unit dispatcher and counts completions.
- Exposes start/running/finished status and dispatched/finished counters for polling.

Parameters:
- BaseAddr, 32'hFFFFFF00, base of the 5-word register window.
- AddrWidth, 32, register-bus address width.
- PcWidth, 32, width of the PC and dp_addr registers.
- TblockCntWidth, 8, width of the tblock count, tblock IDs and both counters.
- TgroupIdWidth, 8, width of the thread-group ID.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  1  register request valid
- req_ready_o  out  1  request accepted; tied to 1
- req_addr_i  in  AddrWidth  byte address
- req_we_i  in  1  1 = write, 0 = read
- req_wdata_i  in  32  write data
- req_be_i  in  4  byte enables
- rsp_valid_o  out  1  response valid, exactly one cycle after acceptance
- rsp_rdata_o  out  32  read data; 0 on writes or errors
- rsp_error_o  out  1  access error
- tblock_valid_o  out  1  thread block offered to the dispatcher
- tblock_ready_i  in  1  dispatcher accepts the offered block
- tblock_pc_o  out  PcWidth  kernel start PC
- tblock_dp_addr_o  out  PcWidth  data-pointer address
- tblock_id_o  out  TblockCntWidth  ID of the offered block
- tblock_tgroup_o  out  TgroupIdWidth  thread-group ID
- tblock_done_i  in  1  one-cycle pulse: one block finished
- busy_o  out  1  high while running

Behaviour:
- Reset (rst_ni=0 at a clk_i edge) clears all registers, counters, FSM, rsp_valid_o, rsp_error_o, rsp_rdata_o and tblock_valid_o.
- Register map (offset = addr - BaseAddr):
  - 0x00: PC, RW.
  - 0x04: DP_ADDR, RW.
  - 0x08: NUM_TBLOCKS, RW; low TblockCntWidth bits stored, upper bits read 0.
  - 0x0C: TGROUP, RW; low TgroupIdWidth bits stored.
  - 0x10: CTRL/STATUS. Any write = start request. Read layout: [0] start_pending, [1] running, [2] finished, [11:4] finished_cnt, [31:24] dispatched_cnt, other bits 0.
- Writes to 0x00–0x0C honour req_be_i per byte.
- Errors, with no state change and rsp_rdata_o=0:
  - Address outside the window, or not word-aligned.
  - Config write (0x00–0x0C) while running.
  - CTRL write while running or start_pending.
- FSM states: IDLE, LAUNCH, DISPATCH, WAIT_DONE, DONE.
  - IDLE/DONE + valid CTRL write: set start_pending; clear finished, dispatched_cnt, finished_cnt. Go to LAUNCH.
  - LAUNCH (1 cycle): clear start_pending. If NUM_TBLOCKS==0, go to DONE; otherwise go to DISPATCH.
  - DISPATCH: tblock_valid_o=1, tblock_id_o=dispatched_cnt. Outputs are stable until tblock_valid_o && tblock_ready_i; then dispatched_cnt++. When the count reaches NUM_TBLOCKS, drop valid the next cycle and go to WAIT_DONE.
  - WAIT_DONE: stay until finished_cnt==NUM_TBLOCKS, then go to DONE.
  - DONE: finished=1. Remain until the next start.
- running = state in {LAUNCH, DISPATCH, WAIT_DONE}; busy_o = running.
- tblock_done_i increments finished_cnt in DISPATCH and WAIT_DONE only; ignored elsewhere.
- finished_cnt never exceeds dispatched_cnt: a pulse that would exceed it is dropped.
- Handshake and done pulse in the same cycle: both counters update.
- Counters do not wrap, since NUM_TBLOCKS ≤ 2^TblockCntWidth-1.
- Reads return the register state before any same-cycle update.
- Reset mid-run drops tblock_valid_o immediately and returns the FSM to IDLE. The dispatcher must be reset alongside this block.

Decomposition:
- Shared package bgpu_dispatch_pkg holds:
  - Register offset constants: DispPcOff, DispDpOff, DispNumOff, DispTgroupOff, DispCtrlOff.
  - Status bit-position constants.
  - dispatch_state_e.
  - A packed tblock_req_t {pc, dp_addr, id, tgroup}.
- Natural sub-module: bgpu_dispatch_fsm (FSM plus counters). The top level keeps bus decode and the config registers.

Test Plan:
- Reset, then read each of 0x00–0x10 → rdata 0, rsp_error_o 0, rsp_valid_o exactly one cycle after each request.
- Write PC=0, DP_ADDR=0x190, NUM=1, TGROUP=2, read each back → values match. Write 0xFFFFFF20 → rsp_error_o=1.
- Write CTRL → one LAUNCH cycle, then tblock_valid_o with pc=0, dp=0x190, id=0, tgroup=2. Hold tblock_ready_i=0 for 5 cycles → outputs stable. Raise it → status reads 0x01000002.
- Pulse tblock_done_i → status reads 0x01000014 and busy_o=0. Write PC mid-run in a NUM=3 launch → error, PC unchanged.
- NUM=4, tblock_ready_i always 1, done pulse in the same cycle as the 2nd handshake → ids 0,1,2,3 in consecutive cycles; after 3 more pulses status 0x04000044.
- NUM=0 start → finished after 2 cycles with counts 0. Assert rst_ni during DISPATCH → tblock_valid_o=0 next cycle, all reads 0.
